// File: rtl/scan_cfg_ctrl.sv
// Scan configuration chain loader: shifts CHAIN_LEN serial bits into a chain,
// waits SETTLE_CYC idle cycles, then releases the loaded configuration.
module scan_cfg_ctrl #(
   parameter int CHAIN_LEN  = 64,
   parameter int SETTLE_CYC = 2
) (
   input  logic                             CK,
   input  logic                             RST,
   input  logic                             START,
   input  logic                             ABORT,
   input  logic                             DIN,
   input  logic                             DIN_VALID,
   output logic                             DIN_READY,
   output logic                             SE,
   output logic                             SI,
   output logic                             SCK_EN,
   output logic                             CFGE,
   output logic                             BUSY,
   output logic                             DONE,
   output logic [$clog2(CHAIN_LEN+1)-1:0]   BIT_CNT
);

   localparam int CNT_W = $clog2(CHAIN_LEN + 1);
   localparam logic [CNT_W-1:0] LAST_M1   = CNT_W'(CHAIN_LEN - 1);
   localparam logic [7:0]       SETTLE_M1 = 8'(SETTLE_CYC - 1);

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      FLUSH,
      SETTLE,
      ACTIVE
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       settle_q, settle_d;
   logic             se_d, si_d, sck_d, cfge_d, busy_d, done_d;
   logic [CNT_W-1:0] cnt_d;
   logic             xfer;

   assign DIN_READY = (state_q == SHIFT) && !ABORT;
   assign xfer      = DIN_READY && DIN_VALID;

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      se_d     = SE;
      si_d     = SI;
      sck_d    = 1'b0;
      cfge_d   = CFGE;
      done_d   = 1'b0;
      cnt_d    = BIT_CNT;
      case (state_q)
         IDLE, ACTIVE: begin
            if (START) begin
               state_d = SHIFT;
               se_d    = 1'b1;
               cfge_d  = 1'b0;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            if (ABORT) begin
               state_d = IDLE;
               se_d    = 1'b0;
               cfge_d  = 1'b0;
            end else if (xfer) begin
               si_d  = DIN;
               sck_d = 1'b1;
               cnt_d = BIT_CNT + 1'b1;
               // SE stays high through FLUSH so the final pulse shifts with SE=1
               if (BIT_CNT == LAST_M1) state_d = FLUSH;
            end
         end
         FLUSH: begin
            se_d = 1'b0;
            if (ABORT) begin
               state_d = IDLE;
               cfge_d  = 1'b0;
            end else begin
               state_d  = SETTLE;
               settle_d = '0;
            end
         end
         SETTLE: begin
            if (ABORT) begin
               state_d = IDLE;
               se_d    = 1'b0;
               cfge_d  = 1'b0;
            end else if (settle_q == SETTLE_M1) begin
               state_d = ACTIVE;
               cfge_d  = 1'b1;
               done_d  = 1'b1;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            se_d    = 1'b0;
            cfge_d  = 1'b0;
         end
      endcase
      busy_d = (state_d == SHIFT) || (state_d == FLUSH) || (state_d == SETTLE);
   end

   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         state_q  <= IDLE;
         settle_q <= '0;
         SE       <= 1'b0;
         SI       <= 1'b0;
         SCK_EN   <= 1'b0;
         CFGE     <= 1'b0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         BIT_CNT  <= '0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         SE       <= se_d;
         SI       <= si_d;
         SCK_EN   <= sck_d;
         CFGE     <= cfge_d;
         BUSY     <= busy_d;
         DONE     <= done_d;
         BIT_CNT  <= cnt_d;
      end
   end

endmodule

// File: tb/tb_scan_cfg_ctrl.sv
// Bench for scan_cfg_ctrl: transaction-level load model checked every cycle,
// plus literal timing and bit-order checks for the directed scenarios.
module tb_scan_cfg_ctrl;

   localparam int CHAIN_LEN  = 8;
   localparam int SETTLE_CYC = 2;

   logic CK = 1'b0;
   logic RST, START, ABORT, DIN, DIN_VALID;
   logic DIN_READY, SE, SI, SCK_EN, CFGE, BUSY, DONE;
   logic [$clog2(CHAIN_LEN+1)-1:0] BIT_CNT;

   scan_cfg_ctrl #(.CHAIN_LEN(CHAIN_LEN), .SETTLE_CYC(SETTLE_CYC)) dut (
      .CK(CK), .RST(RST), .START(START), .ABORT(ABORT), .DIN(DIN),
      .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY), .SE(SE), .SI(SI),
      .SCK_EN(SCK_EN), .CFGE(CFGE), .BUSY(BUSY), .DONE(DONE), .BIT_CNT(BIT_CNT)
   );

   always #5 CK = ~CK;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   // Model: a load is "in flight" from START until release; m_post counts
   // cycles since the final bit was shifted (-1 while bits are still owed).
   bit m_load, m_act, m_si, m_sck, m_done;
   int m_cnt, m_post;

   // Observation of the DUT for the literal checks
   logic [7:0] cap;
   int npulse, pulse8_cyc, done_cyc, cfge_cyc;
   logic prev_cfge;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_load = 0; m_act = 0; m_si = 0; m_sck = 0; m_done = 0;
      m_cnt = 0; m_post = -1;
   endtask

   task automatic model_step(input bit s, input bit a, input bit d, input bit v);
      if (RST) begin
         model_reset();
         return;
      end
      m_sck  = 0;
      m_done = 0;
      if (!m_load) begin
         if (s) begin
            m_load = 1; m_act = 0; m_cnt = 0; m_post = -1;
         end
      end else if (a) begin
         m_load = 0;
      end else if (m_post < 0) begin
         if (v) begin
            m_si = d; m_sck = 1; m_cnt++;
            if (m_cnt == CHAIN_LEN) m_post = 0;
         end
      end else begin
         m_post++;
         if (m_post == 1 + SETTLE_CYC) begin
            m_load = 0; m_act = 1; m_done = 1;
         end
      end
   endtask

   function automatic int exp_ready();
      return int'(m_load && m_post < 0 && !ABORT);
   endfunction

   task automatic compare_all();
      chk("SE", int'(SE), int'(m_load && m_post <= 0));
      chk("BUSY", int'(BUSY), int'(m_load));
      chk("CFGE", int'(CFGE), int'(m_act));
      chk("DONE", int'(DONE), int'(m_done));
      chk("SCK_EN", int'(SCK_EN), int'(m_sck));
      chk("SI", int'(SI), int'(m_si));
      chk("BIT_CNT", int'(BIT_CNT), m_cnt);
      chk("DIN_READY", int'(DIN_READY), exp_ready());
   endtask

   task automatic tick(input bit s, input bit a, input bit d, input bit v);
      START = s; ABORT = a; DIN = d; DIN_VALID = v;
      #1 chk("DIN_READY_pre", int'(DIN_READY), exp_ready());
      @(posedge CK);
      cyc++;
      model_step(s, a, d, v);
      @(negedge CK);
      compare_all();
      if (SCK_EN) begin
         cap = {cap[6:0], SI};
         npulse++;
         if (npulse == CHAIN_LEN) pulse8_cyc = cyc;
      end
      if (DONE) done_cyc = cyc;
      if (CFGE && !prev_cfge) cfge_cyc = cyc;
      prev_cfge = CFGE;
   endtask

   task automatic clear_obs();
      cap = '0; npulse = 0; pulse8_cyc = -1; done_cyc = -1; cfge_cyc = -1;
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 40 && done_cyc < 0; i++) tick(0, 0, 0, 0);
      chk(name, int'(done_cyc >= 0), 1);
   endtask

   initial begin
      logic [7:0] pat;
      int start_cyc;
      pat = 8'b10100101;
      RST = 1; START = 0; ABORT = 0; DIN = 0; DIN_VALID = 0;
      prev_cfge = 0;
      model_reset();
      clear_obs();
      @(negedge CK); @(negedge CK);
      compare_all();
      chk("rst_BIT_CNT", int'(BIT_CNT), 0);
      RST = 0;
      tick(0, 1, 0, 1);  // ABORT in IDLE is ignored

      // Directed load, DIN_VALID held high
      clear_obs();
      tick(1, 0, 0, 0);
      start_cyc = cyc;
      for (int i = 7; i >= 0; i--) tick(0, 0, pat[i], 1);
      wait_done("load1_done");
      chk("load1_bits", int'(cap), int'(8'b10100101));
      chk("load1_pulses", npulse, 8);
      chk("load1_latency", done_cyc - start_cyc, CHAIN_LEN + 1 + SETTLE_CYC);
      tick(0, 1, 0, 0);  // ABORT in ACTIVE is ignored
      tick(0, 0, 0, 0);

      // START during ACTIVE, then gapped valid 1,0,0,1,...
      clear_obs();
      tick(1, 0, 0, 0);
      chk("restart_CFGE", int'(CFGE), 0);
      chk("restart_BIT_CNT", int'(BIT_CNT), 0);
      for (int i = 0; i < 60 && npulse < CHAIN_LEN; i++)
         tick(i % 7 == 2, 0, 1'($urandom), (i % 3) == 0);
      wait_done("gap_done");
      chk("gap_pulses", npulse, 8);
      chk("gap_release", cfge_cyc - pulse8_cyc, SETTLE_CYC + 1);

      // ABORT when BIT_CNT is 5 with DIN_VALID high
      clear_obs();
      tick(1, 0, 0, 0);
      for (int i = 0; i < 20 && m_cnt < 5; i++) tick(0, 0, 1'($urandom), 1);
      tick(0, 1, 1, 1);
      chk("abort_BUSY", int'(BUSY), 0);
      chk("abort_CFGE", int'(CFGE), 0);
      chk("abort_SCK_EN", int'(SCK_EN), 0);
      chk("abort_pulses", npulse, 5);
      for (int i = 0; i < 6; i++) tick(0, 0, 1, 1);
      chk("abort_no_done", done_cyc, -1);

      // Asynchronous reset in the middle of a load
      clear_obs();
      tick(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) tick(0, 0, 1, 1);
      #2 RST = 1;
      #1;
      chk("arst_SE", int'(SE), 0);
      chk("arst_SI", int'(SI), 0);
      chk("arst_SCK_EN", int'(SCK_EN), 0);
      chk("arst_BUSY", int'(BUSY), 0);
      chk("arst_BIT_CNT", int'(BIT_CNT), 0);
      model_reset();
      @(negedge CK);
      tick(0, 0, 1, 1);
      RST = 0;
      for (int i = 0; i < 3; i++) tick(0, 0, 1, 1);
      chk("arst_no_resume", int'(BUSY), 0);
      clear_obs();
      tick(1, 0, 0, 0);
      for (int i = 0; i < CHAIN_LEN; i++) tick(0, 0, 1'($urandom), 1);
      wait_done("arst_reload_done");
      chk("arst_reload_pulses", npulse, 8);

      // Randomised traffic, including ABORT in FLUSH/SETTLE and stray STARTs
      for (int i = 0; i < 600; i++)
         tick($urandom_range(0, 14) == 0, $urandom_range(0, 24) == 0,
              1'($urandom), $urandom_range(0, 3) != 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/scan_cfg_ctrl.md
SCAN_CFG_CTRL -- requirements
Module: scan_cfg_ctrl

Interface
- REQ-001: The module SHALL have parameter CHAIN_LEN, default 64, giving the number of scan flops in the driven configuration chain (legal range 1..65535).
- REQ-002: The module SHALL have parameter SETTLE_CYC, default 2, giving the number of idle cycles between the last shift and configuration release (legal range 1..255).
- REQ-003: The module SHALL have port CK, input, 1 bit: the single clock; all state changes on its posedge.
- REQ-004: The module SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
- REQ-005: The module SHALL have port START, input, 1 bit: request to begin a full chain load.
- REQ-006: The module SHALL have port ABORT, input, 1 bit: cancels an in-progress load.
- REQ-007: The module SHALL have port DIN, input, 1 bit: serial configuration bit, first bit equals the bit destined for the far end of the chain.
- REQ-008: The module SHALL have port DIN_VALID, input, 1 bit: DIN is valid.
- REQ-009: The module SHALL have port DIN_READY, output, 1 bit: controller accepts DIN this cycle.
- REQ-010: The module SHALL have port SE, output, 1 bit: scan enable to the chain.
- REQ-011: The module SHALL have port SI, output, 1 bit: scan data into the chain head.
- REQ-012: The module SHALL have port SCK_EN, output, 1 bit: one-cycle clock-enable pulse per shift, for chain clock gating.
- REQ-013: The module SHALL have port CFGE, output, 1 bit: configure enable releasing the loaded values to the fabric.
- REQ-014: The module SHALL have port BUSY, output, 1 bit: load in progress.
- REQ-015: The module SHALL have port DONE, output, 1 bit: one-cycle pulse on configuration release.
- REQ-016: The module SHALL have port BIT_CNT, output, clog2(CHAIN_LEN+1) bits: number of bits shifted in the current load.

Function
- REQ-017: The module SHALL implement an FSM with states IDLE, SHIFT, FLUSH, SETTLE and ACTIVE; all outputs except DIN_READY SHALL be registered.
- REQ-018: In IDLE or ACTIVE, START=1 SHALL move the FSM to SHIFT on the next edge, setting SE=1, CFGE=0 and BIT_CNT=0 in that same cycle.
- REQ-019: START SHALL be ignored in SHIFT, FLUSH and SETTLE.
- REQ-020: DIN_READY SHALL be combinationally 1 only when the state is SHIFT and ABORT=0.
- REQ-021: A transfer SHALL occur when DIN_VALID and DIN_READY are both 1; on the next cycle SI=DIN, SCK_EN=1 and BIT_CNT increments by 1.
- REQ-022: In cycles with no transfer, SCK_EN SHALL be 0 and SI SHALL hold its value; DIN_VALID gaps of any length SHALL be tolerated.
- REQ-023: The transfer that makes BIT_CNT reach CHAIN_LEN SHALL move the FSM to FLUSH, with SE still 1 so the final SCK_EN pulse shifts with SE=1.
- REQ-024: FLUSH SHALL last exactly 1 cycle, then go to SETTLE with SE=0.
- REQ-025: SETTLE SHALL last exactly SETTLE_CYC cycles, then go to ACTIVE.
- REQ-026: On entry to ACTIVE, CFGE SHALL become 1 and DONE SHALL pulse 1 for exactly one cycle.
- REQ-027: In ACTIVE, CFGE SHALL stay 1 and BIT_CNT SHALL hold CHAIN_LEN until the next START.
- REQ-028: BUSY SHALL be 1 exactly while the state is SHIFT, FLUSH or SETTLE.
- REQ-029: ABORT=1 in SHIFT, FLUSH or SETTLE SHALL return the FSM to IDLE on the next edge, with SE=0, SCK_EN=0, CFGE=0 and no DONE pulse.
- REQ-030: ABORT SHALL win over a simultaneous transfer, i.e. the DIN bit is not accepted.
- REQ-031: ABORT SHALL be ignored in IDLE and ACTIVE.
- REQ-032: Latency SHALL be CHAIN_LEN+1+SETTLE_CYC cycles from the START edge to CFGE=1 when DIN_VALID is held at 1.

Reset
- REQ-033: RST=1 SHALL asynchronously force state IDLE, SE=0, SI=0, SCK_EN=0, CFGE=0, BUSY=0, DONE=0 and BIT_CNT=0, including during SHIFT or ACTIVE.
- REQ-034: After RST deasserts, the module SHALL wait for a new START and SHALL NOT resume a partial load.

Verification
- REQ-035: Check CHAIN_LEN=8, SETTLE_CYC=2, DIN_VALID held 1, bits 1,0,1,0,0,1,0,1 -> 8 SCK_EN pulses with SI matching the stimulus in order; SE falls 1 cycle after the last pulse; CFGE=1 and DONE pulses at cycle 11 after START.
- REQ-036: Check DIN_VALID toggling 1,0,0,1,... -> SCK_EN pulses only on accepted bits; BIT_CNT reaches 8; CFGE asserts exactly SETTLE_CYC+1 cycles after the 8th pulse.
- REQ-037: Check ABORT at BIT_CNT=5 with DIN_VALID=1 that cycle -> no 6th pulse; IDLE next cycle; BUSY=0, CFGE=0, no DONE.
- REQ-038: Check START during ACTIVE -> CFGE drops to 0 on the next edge, BIT_CNT=0; a full reload completes; START pulsed during SHIFT has no effect.
- REQ-039: Check RST asserted mid-SHIFT, asynchronously off-edge -> all outputs 0 immediately; a subsequent START performs a full 8-bit load.
